fir_serial_mac: RTL and testbench

- Serial 64-tap FIR multiply-accumulate engine that consumes the coefficient stream from the coefficient control stage.
- Drives the tap index (current_count) to that stage.
- Reads back the selected coefficient on product_mux in the same cycle and accumulates one tap per cycle.
- Holds the 64-sample delay line and emits one filtered 16-bit sample per accepted input sample; sits between the audio input register and the band output summer.

---
 rtl/fir_serial_mac.sv | 150 +++++++++++++++
 tb/tb_fir_serial_mac.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_serial_mac.sv
// fir_serial_mac: serial 64-tap FIR multiply-accumulate engine.
// Each accepted sample is shifted into a 64-entry delay line. The engine then
// walks current_count 0..63. The coefficient stage returns the matching
// coefficient on product_mux in the same cycle, and one product is
// accumulated per enabled clock. A rounded 16-bit result is emitted with a
// one-cycle out_valid pulse.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   clk_enable       global advance enable; all state holds while low
//   sample_in        signed input sample
//   sample_valid     input sample offered (taken only when in_ready)
//   in_ready         engine idle, able to accept a sample
//   current_count    tap index presented to the coefficient stage
//   product_mux      signed Q1.15 coefficient for current_count (combinational)
//   coeff_update_ok  high only while idle; upstream may swap coefficients
//   out_data         signed filtered sample
//   out_valid        one-cycle pulse qualifying out_data
//
// Build option:
//   FIR_MAC_SATURATE_EN  defined: the rounded result is clamped to the 16-bit
//                        range. Undefined: the low 16 bits are kept, so the
//                        result wraps in two's complement.
module fir_serial_mac #(
  parameter int TAPS = 64,
  parameter int DW   = 16,
  parameter int AW   = 38
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_enable,
  input  logic [DW-1:0] sample_in,
  input  logic          sample_valid,
  output logic          in_ready,
  output logic [5:0]    current_count,
  input  logic [DW-1:0] product_mux,
  output logic          coeff_update_ok,
  output logic [DW-1:0] out_data,
  output logic          out_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [5:0] LAST_TAP = 6'(TAPS - 1);
  localparam int         RW       = AW - 15;  // width of the rounded result

  state_t                  state;
  logic signed [DW-1:0]    taps [TAPS];
  logic signed [AW-1:0]    acc;
  logic signed [2*DW-1:0]  prod_reg;
  logic                    prod_valid;

  logic signed [DW-1:0]    tap_sel;
  logic signed [2*DW-1:0]  product;
  logic signed [AW-1:0]    prod_ext;
  logic signed [AW-1:0]    rounded;
  logic signed [RW-1:0]    r;
  logic [DW-1:0]           converted;

  assign tap_sel  = taps[current_count];
  assign product  = tap_sel * $signed(product_mux);
  assign prod_ext = {{(AW-2*DW){prod_reg[2*DW-1]}}, prod_reg};

  // Round half up, then arithmetic shift right by 15.
  // Keeping the top bits of the rounded sum is the same as an arithmetic shift.
  assign rounded = acc + AW'(16384);
  assign r       = rounded[AW-1:15];

`ifdef FIR_MAC_SATURATE_EN
  logic sat_hi;
  logic sat_lo;

  // The result is out of range when the bits above bit 15 are not all copies
  // of the sign bit.
  assign sat_hi = ~r[RW-1] & (|r[RW-1:DW-1]);
  assign sat_lo =  r[RW-1] & ~(&r[RW-1:DW-1]);

  always_comb begin
    converted = r[DW-1:0];
    if (sat_hi) converted = {1'b0, {(DW-1){1'b1}}};
    if (sat_lo) converted = {1'b1, {(DW-1){1'b0}}};
  end
`else
  always_comb begin
    converted = r[DW-1:0];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      for (int unsigned k = 0; k < TAPS; k++) taps[k] <= '0;
      acc             <= '0;
      prod_reg        <= '0;
      prod_valid      <= 1'b0;
      current_count   <= '0;
      out_data        <= '0;
      out_valid       <= 1'b0;
      in_ready        <= 1'b1;
      coeff_update_ok <= 1'b1;
    end else if (clk_enable) begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_valid) begin
            for (int unsigned k = TAPS - 1; k > 0; k--) taps[k] <= taps[k-1];
            taps[0]         <= $signed(sample_in);
            acc             <= '0;
            current_count   <= '0;
            in_ready        <= 1'b0;
            coeff_update_ok <= 1'b0;
            state           <= MAC;
          end
        end
        MAC: begin
          // The product is registered one tap behind the index, so the
          // accumulator lags by a cycle and DRAIN adds the final product.
          prod_reg   <= product;
          prod_valid <= 1'b1;
          if (prod_valid) acc <= acc + prod_ext;
          if (current_count == LAST_TAP) begin
            state <= DRAIN;
          end else begin
            current_count <= current_count + 6'd1;
          end
        end
        DRAIN: begin
          acc        <= acc + prod_ext;
          prod_valid <= 1'b0;
          state      <= DONE;
        end
        DONE: begin
          out_data        <= converted;
          out_valid       <= 1'b1;
          current_count   <= '0;
          in_ready        <= 1'b1;
          coeff_update_ok <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// tb_fir_serial_mac: self-checking bench for fir_serial_mac.
// The coefficient stage is modelled as a table indexed by current_count.
// Expected outputs are computed as a plain dot product over a reference
// delay line, followed by round-half-up and the build-selected narrowing.
module tb_fir_serial_mac;

  logic        clk;
  logic        rst;
  logic        clk_enable;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        in_ready;
  logic [5:0]  current_count;
  logic [15:0] product_mux;
  logic        coeff_update_ok;
  logic [15:0] out_data;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] coeff [64];
  longint             model_taps [64];

  fir_serial_mac #(.TAPS(64), .DW(16), .AW(38)) dut (
    .clk             (clk),
    .rst             (rst),
    .clk_enable      (clk_enable),
    .sample_in       (sample_in),
    .sample_valid    (sample_valid),
    .in_ready        (in_ready),
    .current_count   (current_count),
    .product_mux     (product_mux),
    .coeff_update_ok (coeff_update_ok),
    .out_data        (out_data),
    .out_valid       (out_valid)
  );

  assign product_mux = coeff[current_count];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: y = round_half_up(sum(x[k] * c[k]) / 2^15), then narrowed.
  function automatic logic [15:0] model_out();
    longint sum;
    longint r;
    sum = 0;
    for (int k = 0; k < 64; k++) sum += model_taps[k] * longint'(coeff[k]);
    r = (sum + 64'sd16384) >>> 15;
`ifdef FIR_MAC_SATURATE_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  function automatic logic [15:0] model_push(input logic [15:0] s);
    for (int k = 63; k > 0; k--) model_taps[k] = model_taps[k-1];
    model_taps[0] = longint'($signed(s));
    return model_out();
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 64; k++) model_taps[k] = 0;
  endtask

  task automatic set_all_coeffs(input logic signed [15:0] v);
    for (int k = 0; k < 64; k++) coeff[k] = v;
  endtask

  task automatic set_random_coeffs();
    for (int k = 0; k < 64; k++) coeff[k] = 16'($urandom);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;
    clk_enable   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  // Offer one sample while idle, then wait for its result. The sample is
  // taken at edge E0, and the result is expected right after edge E0+66.
  task automatic run_sample(input logic [15:0] s, input string name,
                            output logic [15:0] got);
    logic [15:0] exp;
    int lat;
    exp = model_push(s);
    sample_in    = s;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = out_data;
    checks++;
    if (lat != 66) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected 66", name, lat);
    end
    checks++;
    if (out_data !== exp) begin
      errors++;
      $display("FAIL %s data: got %0d, expected %0d", name, $signed(out_data), $signed(exp));
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b, expected 1", in_ready); end
    checks++;
    if (coeff_update_ok !== 1'b1) begin errors++; $display("FAIL reset coeff_update_ok: got %b, expected 1", coeff_update_ok); end
    checks++;
    if (current_count !== 6'd0) begin errors++; $display("FAIL reset current_count: got %0d, expected 0", current_count); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b, expected 0", out_valid); end
    checks++;
    if (out_data !== 16'd0) begin errors++; $display("FAIL reset out_data: got %0d, expected 0", out_data); end
  endtask

  task automatic test_impulse();
    logic [15:0] got;
    do_reset();
    set_all_coeffs(16'sd0);
    coeff[0] = 16'sd16384;
    run_sample(16'd1000, "impulse", got);
    checks++;
    if (got !== 16'd500) begin errors++; $display("FAIL impulse value: got %0d, expected 500", $signed(got)); end
  endtask

  // Only tap 3 carries weight, so the output is the sample taken three
  // samples earlier. The fourth output therefore comes from the first sample.
  task automatic test_shift();
    logic [15:0] got;
    logic [15:0] want [4];
    want[0] = 16'd0; want[1] = 16'd0; want[2] = 16'd0; want[3] = 16'd100;
    do_reset();
    set_all_coeffs(16'sd0);
    coeff[3] = 16'sd32767;
    for (int i = 0; i < 4; i++) begin
      run_sample(16'((i + 1) * 100), "shift", got);
      checks++;
      if (got !== want[i]) begin
        errors++;
        $display("FAIL shift out%0d: got %0d, expected %0d", i + 1, $signed(got), $signed(want[i]));
      end
    end
  endtask

  task automatic test_dc();
    logic [15:0] got;
    do_reset();
    set_all_coeffs(16'sd512);
    for (int i = 0; i < 64; i++) begin
      run_sample(16'd6400, "dc", got);
      if (i == 0) begin
        checks++;
        if (got !== 16'd100) begin errors++; $display("FAIL dc first: got %0d, expected 100", $signed(got)); end
      end
      if (i == 63) begin
        checks++;
        if (got !== 16'd6400) begin errors++; $display("FAIL dc last: got %0d, expected 6400", $signed(got)); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] got;
    logic [15:0] want;
`ifdef FIR_MAC_SATURATE_EN
    want = 16'h7FFF;
`else
    want = 16'hFF80;
`endif
    do_reset();
    set_all_coeffs(16'sd32767);
    for (int i = 0; i < 64; i++) run_sample(16'd32767, "overflow", got);
    checks++;
    if (got !== want) begin errors++; $display("FAIL overflow last: got %h, expected %h", got, want); end
  endtask

  task automatic test_random();
    logic [15:0] got;
    do_reset();
    set_random_coeffs();
    for (int i = 0; i < 20; i++) run_sample(16'($urandom), "random", got);
  endtask

  // sample_valid stays high throughout. The bench tracks the expected busy
  // window and checks the handshake outputs on every cycle.
  task automatic test_back_to_back();
    int busy;
    bit pend;
    logic [15:0] pend_val;
    logic [15:0] s;
    bit exp_ready;
    bit exp_ov;
    do_reset();
    set_random_coeffs();
    busy = 0;
    pend = 0;
    pend_val = '0;
    sample_valid = 1'b1;
    for (int cyc = 0; cyc < 210; cyc++) begin
      exp_ready = (busy == 0);
      exp_ov    = pend && (busy == 0);
      checks++;
      if (in_ready !== exp_ready) begin
        errors++; $display("FAIL b2b in_ready cyc %0d: got %b, expected %b", cyc, in_ready, exp_ready);
      end
      checks++;
      if (coeff_update_ok !== exp_ready) begin
        errors++; $display("FAIL b2b coeff_update_ok cyc %0d: got %b, expected %b", cyc, coeff_update_ok, exp_ready);
      end
      checks++;
      if (out_valid !== exp_ov) begin
        errors++; $display("FAIL b2b out_valid cyc %0d: got %b, expected %b", cyc, out_valid, exp_ov);
      end
      if (exp_ov) begin
        checks++;
        if (out_data !== pend_val) begin
          errors++; $display("FAIL b2b data cyc %0d: got %0d, expected %0d", cyc, $signed(out_data), $signed(pend_val));
        end
        pend = 0;
      end
      s = 16'($urandom);
      sample_in = s;
      if (exp_ready) begin
        pend_val = model_push(s);
        pend = 1;
        busy = 67;
      end
      @(posedge clk);
      #1;
      if (busy > 0) busy--;
    end
    sample_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic [15:0] exp;
    logic [5:0] cc_hold;
    int lat;
    do_reset();
    set_random_coeffs();
    exp = model_push(16'($urandom));
    sample_in = 16'(model_taps[0]);
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    lat = 0;
    repeat (30) begin @(posedge clk); #1; lat++; end
    cc_hold = current_count;
    clk_enable = 1'b0;
    repeat (10) begin @(posedge clk); #1; lat++; end
    checks++;
    if (current_count !== cc_hold) begin
      errors++; $display("FAIL stall frozen count: got %0d, expected %0d", current_count, cc_hold);
    end
    clk_enable = 1'b1;
    while (out_valid !== 1'b1 && lat < 300) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != 76) begin errors++; $display("FAIL stall latency: got %0d cycles, expected 76", lat); end
    checks++;
    if (out_data !== exp) begin errors++; $display("FAIL stall data: got %0d, expected %0d", $signed(out_data), $signed(exp)); end
    clk_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL stall out_valid hold: got %b, expected 1", out_valid); end
    checks++;
    if (out_data !== exp) begin errors++; $display("FAIL stall data hold: got %0d, expected %0d", $signed(out_data), $signed(exp)); end
    clk_enable = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stall out_valid clear: got %b, expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    int wait_cnt;
    int pulses;
    do_reset();
    set_all_coeffs(16'sd0);
    coeff[0] = 16'sd16384;
    sample_in = 16'd1234;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    wait_cnt = 0;
    while (current_count !== 6'd30 && wait_cnt < 100) begin @(posedge clk); #1; wait_cnt++; end
    checks++;
    if (current_count !== 6'd30) begin errors++; $display("FAIL rst_mid reach tap30: got %0d, expected 30", current_count); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid in_ready: got %b, expected 1", in_ready); end
    checks++;
    if (current_count !== 6'd0) begin errors++; $display("FAIL rst_mid current_count: got %0d, expected 0", current_count); end
    #1;
    rst = 1'b0;
    model_clear();
    pulses = 0;
    repeat (80) begin @(posedge clk); #1; if (out_valid === 1'b1) pulses++; end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL rst_mid out_valid pulses: got %0d, expected 0", pulses); end
    run_sample(16'd1000, "rst_mid impulse", got);
    checks++;
    if (got !== 16'd500) begin errors++; $display("FAIL rst_mid impulse value: got %0d, expected 500", $signed(got)); end
    // Older history must be gone: any residue in the delay line would show up
    // in this random-coefficient result.
    set_random_coeffs();
    run_sample(16'($urandom), "rst_mid history", got);
  endtask

  initial begin
    rst = 1'b1;
    clk_enable = 1'b1;
    sample_valid = 1'b0;
    sample_in = '0;
    set_all_coeffs(16'sd0);
    model_clear();
    test_reset();
    test_impulse();
    test_shift();
    test_dc();
    test_overflow();
    test_random();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
